// File: rtl/sample_dma_requester.sv
// Per-voice sample-fetch burst requester: one batch of AXI read bursts per playback
// period, then waits for the receiver to drain the batch before scanning again.
module sample_dma_requester #(
  parameter int NUM_VOICES  = 64,
  parameter int BURST_BEATS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stop,
  input  logic              i_voice_wr,
  input  logic [5:0]        i_voice_wr_id,
  input  logic [ADDR_W-1:0] i_voice_wr_start,
  input  logic [ADDR_W-1:0] i_voice_wr_end,
  input  logic              i_voice_wr_active,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [5:0]        o_req_id,
  output logic [7:0]        o_req_len,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  input  logic              i_all_samples_received,
  output logic              o_last_request_sent,
  output logic [5:0]        o_last_request_id,
  output logic              o_all_samples_invalid,
  output logic [6:0]        o_active_voices
);

  // state   | meaning
  // IDLE    | no batch running; waits for an active voice and ~stop
  // SCAN    | examines one table slot per cycle
  // ISSUE   | holds a burst request until the bridge accepts it
  // FINISH  | one-cycle report of the batch's final request id
  // WAIT_RX | waits for the receiver's batch-complete pulse
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_FINISH, S_WAIT_RX} state_t;

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_BEATS * 4);
  localparam logic [5:0]        LAST_SLOT   = 6'(NUM_VOICES - 1);
  localparam logic [6:0]        NV          = 7'(NUM_VOICES);

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_cur_addr [NUM_VOICES];
  logic [ADDR_W-1:0] r_end_addr [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_active;

  logic [5:0]        r_idx;
  logic              r_issued;
  logic [5:0]        r_last_id;
  logic [ADDR_W-1:0] r_req_addr;
  logic [5:0]        r_req_id;
  logic              r_invalid;
  logic [6:0]        r_active_cnt;

  logic       w_slot_active, w_expired, w_last_slot;
  logic       w_start_req, w_clear_slot, w_idx_inc, w_batch_start, w_hs, w_set_invalid;
  logic [6:0] w_popcount;

  // Compare one bit wider so a slot near the top of the address space cannot wrap.
  assign w_slot_active = r_active[r_idx];
  assign w_expired     = ({1'b0, r_cur_addr[r_idx]} + {1'b0, BURST_BYTES}) > {1'b0, r_end_addr[r_idx]};
  assign w_last_slot   = (r_idx == LAST_SLOT);

  always_comb begin
    w_popcount = '0;
    for (int v = 0; v < NUM_VOICES; v++) w_popcount = w_popcount + 7'(r_active[v]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_req   = 1'b0;
    w_clear_slot  = 1'b0;
    w_idx_inc     = 1'b0;
    w_batch_start = 1'b0;
    w_hs          = 1'b0;
    w_set_invalid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_active_cnt != 7'd0) begin
          w_state_nxt   = S_SCAN;
          w_batch_start = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_slot_active && !w_expired) begin
          w_state_nxt = S_ISSUE;
          w_start_req = 1'b1;
        end else begin
          w_clear_slot = w_expired;
          if (w_last_slot) begin
            if (r_issued) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_state_nxt   = S_IDLE;
              w_set_invalid = 1'b1;
            end
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (i_req_ready) begin
          w_hs = 1'b1;
          if (w_last_slot) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_SCAN;
            w_idx_inc   = 1'b1;
          end
        end
      end
      S_FINISH: w_state_nxt = S_WAIT_RX;
      S_WAIT_RX: begin
        if (i_all_samples_received) begin
          w_state_nxt   = S_SCAN;
          w_batch_start = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Stop discards the batch but leaves the table untouched, so a handshake
    // coinciding with stop does not advance the voice.
    if (i_stop) begin
      w_state_nxt   = S_IDLE;
      w_start_req   = 1'b0;
      w_clear_slot  = 1'b0;
      w_idx_inc     = 1'b0;
      w_hs          = 1'b0;
      w_set_invalid = 1'b0;
      w_batch_start = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_cur_addr[v] <= '0;
        r_end_addr[v] <= '0;
      end
      r_active <= '0;
    end else begin
      if (w_clear_slot) r_active[r_idx] <= 1'b0;
      if (w_hs) r_cur_addr[r_idx] <= r_cur_addr[r_idx] + BURST_BYTES;
      // Host writes are last so they override a same-cycle advance or expiry clear.
      if (i_voice_wr && ({1'b0, i_voice_wr_id} < NV)) begin
        r_cur_addr[i_voice_wr_id] <= i_voice_wr_start;
        r_end_addr[i_voice_wr_id] <= i_voice_wr_end;
        r_active[i_voice_wr_id]   <= i_voice_wr_active;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx        <= '0;
      r_issued     <= 1'b0;
      r_last_id    <= '0;
      r_req_addr   <= '0;
      r_req_id     <= '0;
      r_invalid    <= 1'b1;
      r_active_cnt <= '0;
    end else begin
      r_active_cnt <= w_popcount;
      if (w_batch_start) begin
        r_idx    <= '0;
        r_issued <= 1'b0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 6'd1;
      end
      if (w_start_req) begin
        r_req_addr <= r_cur_addr[r_idx];
        r_req_id   <= r_idx;
      end
      if (w_hs) begin
        r_issued  <= 1'b1;
        r_last_id <= r_req_id;
      end
      if (w_set_invalid)         r_invalid <= 1'b1;
      else if (r_state == S_IDLE) r_invalid <= (r_active_cnt == 7'd0);
    end
  end

  assign o_req_addr            = r_req_addr;
  assign o_req_id              = r_req_id;
  assign o_req_len             = 8'(BURST_BEATS - 1);
  assign o_req_valid           = (r_state == S_ISSUE);
  assign o_last_request_sent   = (r_state == S_FINISH);
  assign o_last_request_id     = r_last_id;
  assign o_all_samples_invalid = r_invalid;
  assign o_active_voices       = r_active_cnt;

endmodule

// File: tb/tb_sample_dma_requester.sv
// Directed bench for sample_dma_requester: inputs change 1 ns after the rising edge,
// outputs are observed on the falling edge.
module tb_sample_dma_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop = 1'b0;
  logic        voice_wr = 1'b0;
  logic [5:0]  voice_wr_id = '0;
  logic [31:0] voice_wr_start = '0;
  logic [31:0] voice_wr_end = '0;
  logic        voice_wr_active = 1'b0;
  logic        req_ready = 1'b1;
  logic        all_rx = 1'b0;

  logic [31:0] o_req_addr;
  logic [5:0]  o_req_id;
  logic [7:0]  o_req_len;
  logic        o_req_valid;
  logic        o_last_request_sent;
  logic [5:0]  o_last_request_id;
  logic        o_all_samples_invalid;
  logic [6:0]  o_active_voices;

  always #5 clk = ~clk;

  sample_dma_requester #(.NUM_VOICES(64), .BURST_BEATS(64), .ADDR_W(32)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_stop                 (stop),
    .i_voice_wr             (voice_wr),
    .i_voice_wr_id          (voice_wr_id),
    .i_voice_wr_start       (voice_wr_start),
    .i_voice_wr_end         (voice_wr_end),
    .i_voice_wr_active      (voice_wr_active),
    .o_req_addr             (o_req_addr),
    .o_req_id               (o_req_id),
    .o_req_len              (o_req_len),
    .o_req_valid            (o_req_valid),
    .i_req_ready            (req_ready),
    .i_all_samples_received (all_rx),
    .o_last_request_sent    (o_last_request_sent),
    .o_last_request_id      (o_last_request_id),
    .o_all_samples_invalid  (o_all_samples_invalid),
    .o_active_voices        (o_active_voices)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: only ever increments/pushes; tests work on deltas from snapshots.
  int          hs_cnt = 0, pulse_cnt = 0, valid_cnt = 0, inv_low_cnt = 0, act_nz_cnt = 0;
  logic [5:0]  pulse_id = '0;
  logic [5:0]  q_id [$];
  logic [31:0] q_addr [$];

  always @(negedge clk) begin
    if (o_req_valid) valid_cnt++;
    if (!o_all_samples_invalid) inv_low_cnt++;
    if (o_active_voices != 7'd0) act_nz_cnt++;
    if (o_req_valid && req_ready) begin
      hs_cnt++;
      q_id.push_back(o_req_id);
      q_addr.push_back(o_req_addr);
    end
    if (o_last_request_sent) begin
      pulse_cnt++;
      pulse_id = o_last_request_id;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stop = 1'b0; voice_wr = 1'b0; all_rx = 1'b0; req_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wr_voice(input logic [5:0] id, input logic [31:0] s, input logic [31:0] e,
                          input logic act);
    voice_wr = 1'b1; voice_wr_id = id; voice_wr_start = s; voice_wr_end = e; voice_wr_active = act;
    tick();
    voice_wr = 1'b0;
  endtask

  task automatic rx_done();
    all_rx = 1'b1;
    tick();
    all_rx = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input string tag);
    int n = 0;
    while (pulse_cnt < target && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 64'(pulse_cnt >= target), 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!o_req_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid_seen", 64'(o_req_valid), 64'd1);
  endtask

  // Expects a request with req_ready low, optionally stalls, then accepts it for one cycle.
  task automatic accept_req(input logic [5:0] id, input logic [31:0] addr, input int stall);
    logic stable;
    wait_valid();
    chk("req_id", 64'(o_req_id), 64'(id));
    chk("req_addr", 64'(o_req_addr), 64'(addr));
    stable = 1'b1;
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        if (!o_req_valid || o_req_id != id || o_req_addr != addr) stable = 1'b0;
      end
      chk("stall_stable", 64'(stable), 64'd1);
    end
    @(posedge clk);
    #1 req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  int hb, pb, vb, ib, ab;

  initial begin
    do_reset();
    // reset values
    chk("rst_req_valid", 64'(o_req_valid), 64'd0);
    chk("rst_req_addr", 64'(o_req_addr), 64'd0);
    chk("rst_req_id", 64'(o_req_id), 64'd0);
    chk("rst_last_sent", 64'(o_last_request_sent), 64'd0);
    chk("rst_last_id", 64'(o_last_request_id), 64'd0);
    chk("rst_invalid", 64'(o_all_samples_invalid), 64'd1);
    chk("rst_active", 64'(o_active_voices), 64'd0);
    chk("req_len", 64'(o_req_len), 64'd63);

    // no voices armed: nothing happens
    vb = valid_cnt; ib = inv_low_cnt; ab = act_nz_cnt;
    repeat (100) tick();
    chk("idle_no_valid", 64'(valid_cnt - vb), 64'd0);
    chk("idle_invalid_hi", 64'(inv_low_cnt - ib), 64'd0);
    chk("idle_active_zero", 64'(act_nz_cnt - ab), 64'd0);

    // single voice walks 0x1000..0x1300 then expires
    hb = hs_cnt; pb = pulse_cnt;
    wr_voice(6'd5, 32'h1000, 32'h1400, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_pulses(pb + k + 1, "v5_pulse");
      chk("v5_hs_count", 64'(hs_cnt - hb), 64'(k + 1));
      chk("v5_id", 64'(q_id[hb + k]), 64'd5);
      chk("v5_addr", 64'(q_addr[hb + k]), 64'(32'h1000 + 32'h100 * k));
      chk("v5_last_id", 64'(pulse_id), 64'd5);
      chk("v5_active", 64'(o_active_voices), 64'd1);
      chk("v5_valid_fetch", 64'(o_all_samples_invalid), 64'd0);
      rx_done();
    end
    repeat (100) tick();
    chk("v5_expired_hs", 64'(hs_cnt - hb), 64'd4);
    chk("v5_expired_pulses", 64'(pulse_cnt - pb), 64'd4);
    chk("v5_expired_invalid", 64'(o_all_samples_invalid), 64'd1);
    chk("v5_expired_active", 64'(o_active_voices), 64'd0);

    // three voices in one batch
    do_reset();
    stop = 1'b1;
    wr_voice(6'd2, 32'h2000, 32'h3000, 1'b1);
    wr_voice(6'd9, 32'h4000, 32'h5000, 1'b1);
    wr_voice(6'd40, 32'h6000, 32'h7000, 1'b1);
    repeat (3) tick();
    chk("three_active", 64'(o_active_voices), 64'd3);
    hb = hs_cnt; pb = pulse_cnt;
    stop = 1'b0;
    wait_pulses(pb + 1, "b1_pulse");
    chk("b1_hs_count", 64'(hs_cnt - hb), 64'd3);
    chk("b1_id0", 64'(q_id[hb]), 64'd2);
    chk("b1_id1", 64'(q_id[hb + 1]), 64'd9);
    chk("b1_id2", 64'(q_id[hb + 2]), 64'd40);
    chk("b1_addr2", 64'(q_addr[hb + 2]), 64'h6000);
    chk("b1_last_id", 64'(pulse_id), 64'd40);
    repeat (40) tick();
    chk("b1_no_req_before_rx", 64'(hs_cnt - hb), 64'd3);
    chk("b1_single_pulse", 64'(pulse_cnt - pb), 64'd1);

    // second batch with backpressure on id 9
    req_ready = 1'b0;
    hb = hs_cnt;
    rx_done();
    accept_req(6'd2, 32'h2100, 0);
    accept_req(6'd9, 32'h4100, 10);
    accept_req(6'd40, 32'h6100, 0);
    wait_pulses(pb + 2, "b2_pulse");
    chk("b2_hs_count", 64'(hs_cnt - hb), 64'd3);
    chk("b2_last_id", 64'(pulse_id), 64'd40);

    // stop while id 9 is pending, then restart from slot 0
    rx_done();
    accept_req(6'd2, 32'h2200, 0);
    wait_valid();
    chk("stop_pre_id", 64'(o_req_id), 64'd9);
    tick();
    stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stop_valid_drop", 64'(o_req_valid), 64'd0);
    tick();
    hb = hs_cnt; vb = valid_cnt;
    repeat (5) tick();
    chk("stop_hold_no_valid", 64'(valid_cnt - vb), 64'd0);
    stop = 1'b0;
    accept_req(6'd2, 32'h2300, 0);
    accept_req(6'd9, 32'h4200, 0);
    accept_req(6'd40, 32'h6200, 0);
    wait_pulses(pb + 3, "restart_pulse");
    chk("restart_hs_count", 64'(hs_cnt - hb), 64'd3);
    chk("restart_last_id", 64'(pulse_id), 64'd40);

    // host write collides with slot 3 handshake: write wins
    do_reset();
    stop = 1'b1;
    wr_voice(6'd3, 32'h3000, 32'h4000, 1'b1);
    repeat (3) tick();
    req_ready = 1'b0;
    pb = pulse_cnt; hb = hs_cnt;
    stop = 1'b0;
    wait_valid();
    chk("col_id", 64'(o_req_id), 64'd3);
    chk("col_addr", 64'(o_req_addr), 64'h3000);
    tick();
    req_ready = 1'b1;
    voice_wr = 1'b1; voice_wr_id = 6'd3; voice_wr_start = 32'h8000;
    voice_wr_end = 32'h9000; voice_wr_active = 1'b1;
    tick();
    req_ready = 1'b0; voice_wr = 1'b0;
    chk("col_hs", 64'(hs_cnt - hb), 64'd1);
    wait_pulses(pb + 1, "col_pulse");
    chk("col_last_id", 64'(pulse_id), 64'd3);
    rx_done();
    accept_req(6'd3, 32'h8000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sample_dma_requester.md
Name: sample_dma_requester

Overview:
- Issues per-voice sample-fetch burst requests to the AXI bridge read channel, one batch per playback period.
- A batch scans a voice table and requests one burst for every active voice.
- After the last request of a batch it reports that request's ID to the DMA receiver, then waits for the receiver to signal that all samples of the batch were received before starting the next batch.

Parameters:
- NUM_VOICES, 64, voice table slots; max 64 (6-bit ID).
- BURST_BEATS, 64, 32-bit beats per request; must not exceed the receiver mix FIFO depth.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stop  in  1  abort playback; level
- voice_wr  in  1  voice table write strobe
- voice_wr_id  in  6  slot written
- voice_wr_start  in  ADDR_W  first byte address of the sample, 4-byte aligned
- voice_wr_end  in  ADDR_W  byte address one past the last sample word
- voice_wr_active  in  1  1 = arm slot, 0 = kill slot
- req_addr  out  ADDR_W  burst start address
- req_id  out  6  voice slot of the request
- req_len  out  8  BURST_BEATS-1 (AXI len encoding)
- req_valid  out  1  request valid
- req_ready  in  1  bridge accepts request
- all_samples_received  in  1  receiver batch-complete pulse
- last_request_sent  out  1  one-cycle pulse after the final request of a batch
- last_request_id  out  6  ID of the final request; valid with the pulse
- all_samples_invalid  out  1  level: no voice can be fetched
- active_voices  out  7  count of active slots (status)

Behaviour:
- Reset values:
  - req_valid=0, req_addr=0, req_id=0, last_request_sent=0, last_request_id=0.
  - all_samples_invalid=1, active_voices=0.
  - All slots inactive, FSM=IDLE.
- Voice table: per slot cur_addr, end_addr, active.
  - voice_wr loads cur_addr=voice_wr_start, end_addr=voice_wr_end, active=voice_wr_active next cycle.
- Expiry: a slot is expired when cur_addr + BURST_BEATS*4 > end_addr. An expired slot is cleared (active=0) when scanned, and no request is issued for it; any partial tail is dropped.
- FSM states: IDLE, SCAN, ISSUE, FINISH, WAIT_RX.
- IDLE:
  - Go to SCAN with scan index=0 when ~stop and active_voices!=0.
  - all_samples_invalid = (active_voices==0).
- SCAN: one slot per cycle.
  - Active and not expired -> ISSUE.
  - Otherwise: clear the slot if it is expired, then increment the index.
  - After slot NUM_VOICES-1: go to FINISH if at least one request was issued in this batch; otherwise go to IDLE and set all_samples_invalid=1.
- ISSUE:
  - Drive req_valid=1 with req_addr=cur_addr and req_id=slot.
  - Hold req_addr/req_id/req_len stable while req_valid & ~req_ready.
  - On req_valid & req_ready: cur_addr += BURST_BEATS*4, record last_issued_id=slot, increment the index, return to SCAN. If this was the last slot, go to FINISH instead.
- FINISH: pulse last_request_sent=1 for one cycle with last_request_id=last_issued_id, then go to WAIT_RX.
- WAIT_RX: on all_samples_received, go to SCAN with index=0 (next batch).
- Throughput: minimum 2 cycles per issued request; at most NUM_VOICES+requests+1 cycles from batch start to the last_request_sent pulse.
- stop: from any state, at the next edge:
  - FSM=IDLE, req_valid=0, batch state cleared.
  - The voice table is preserved.
  - The bridge tolerates withdrawal of req_valid on stop.
- Collision: when voice_wr targets the slot whose cur_addr advances in the same cycle, voice_wr wins.
- Mid-batch writes:
  - Arming a slot below the scan index takes effect next batch.
  - Killing a slot that has not yet been scanned prevents its request.
  - Killing the slot currently in ISSUE does not withdraw the pending request.
- active_voices: popcount of active bits, registered, 1-cycle lag.
- rst behaves like stop and additionally clears the table.

Test Plan:
- Voice 5 armed with start=0x1000, end=0x1400, BURST_BEATS=64 -> requests: addr 0x1000 id 5, then (after each all_samples_received) 0x1100, 0x1200, 0x1300. The next scan expires the slot -> IDLE, all_samples_invalid=1.
- Voices 2, 9, 40 armed -> a batch issues ids 2, 9, 40 in order, then last_request_sent pulses once with last_request_id=40. No request is issued until all_samples_received.
- req_ready held 0 for 10 cycles during the request for id 9 -> req_valid, req_addr and req_id stay stable; exactly one handshake occurs.
- stop asserted while in ISSUE -> req_valid=0 next cycle, FSM IDLE; on release the batch restarts from slot 0 at the unadvanced cur_addr.
- No voices armed after reset -> req_valid never asserts; all_samples_invalid=1 and active_voices=0 throughout.
- voice_wr to slot 3 (start=0x8000) in the same cycle as the slot 3 handshake -> next batch requests 0x8000.
